// File: rtl/count_reducer.sv
// Sequential Horner reducer: turns packed per-bit lane counts into one signed weighted sum.
// Optional macro REDUCER_RELU_EN publishes max(sum, 0) instead of the full signed sum.
module count_reducer #(
  parameter int SIZE_INPUT = 8,
  parameter int SIZE_CODE  = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [SIZE_INPUT*SIZE_CODE-1:0] countin,
  output logic                            busy,
  output logic                            done,
  output logic [SIZE_INPUT+SIZE_CODE:0]   result
);

  localparam int RESULT_W = SIZE_INPUT + SIZE_CODE + 1;
  localparam int IDX_W    = $clog2(SIZE_INPUT);
  localparam int EXT_W    = RESULT_W - SIZE_CODE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [SIZE_INPUT*SIZE_CODE-1:0] snap;
  logic signed [RESULT_W-1:0]      acc;
  logic signed [RESULT_W-1:0]      acc_step;
  logic signed [RESULT_W-1:0]      top_ext;
  logic signed [RESULT_W-1:0]      lane_ext;
  logic [IDX_W-1:0]                idx;
  logic [SIZE_CODE-1:0]            top_lane;
  logic [SIZE_CODE-1:0]            snap_lane;
  logic                            load;
  logic                            step;
  logic                            last;

  function automatic logic signed [RESULT_W-1:0] publish(input logic signed [RESULT_W-1:0] v);
`ifdef REDUCER_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // The top lane is the two's-complement output of the negative counter; it seeds acc
  // straight from countin so the counter bank may change on the acceptance edge.
  always_comb begin
    top_lane  = countin[(SIZE_INPUT-1)*SIZE_CODE +: SIZE_CODE];
    snap_lane = snap[idx*SIZE_CODE +: SIZE_CODE];
    top_ext   = signed'({{EXT_W{top_lane[SIZE_CODE-1]}}, top_lane});
    lane_ext  = signed'({{EXT_W{1'b0}}, snap_lane});
    acc_step  = (acc <<< 1) + lane_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    last    = (idx == '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // result is only written on the final step, so a reset mid-run never exposes a partial sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap   <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
    end else if (load) begin
      snap <= countin;
      acc  <= top_ext;
      idx  <= IDX_W'(SIZE_INPUT - 2);
    end else if (step) begin
      acc <= acc_step;
      if (last) result <= publish(acc_step);
      else      idx    <= idx - IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_count_reducer.sv
// Bench for count_reducer: vector table plus hand-written multi-cycle sequences, results via scoreboard queue.
module tb_count_reducer;

  localparam int SI = 8;
  localparam int SC = 5;
  localparam int CW = SI * SC;
  localparam int RW = SI + SC + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] countin = '0;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  int sb[$];

  typedef struct {
    logic [CW-1:0] cin;
    int            expv;
  } vec_t;

  vec_t vecs[6];

  count_reducer #(.SIZE_INPUT(SI), .SIZE_CODE(SC)) dut (
    .clk(clk), .reset(reset), .start(start), .countin(countin),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int relu(input int v);
`ifdef REDUCER_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Direct weighted sum, independent of the shift-add recurrence.
  function automatic int model(input logic [CW-1:0] c);
    int s = 0;
    int v;
    logic [SC-1:0] lane;
    for (int i = 0; i < SI; i++) begin
      lane = c[i*SC +: SC];
      v = int'(lane);
      if (i == SI - 1 && lane[SC-1]) v = v - (1 << SC);
      s = s + v * (1 << i);
    end
    return relu(s);
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (prev_done) chk("done_single_cycle", 0, 1);
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else chk("result", int'($signed(result)), sb.pop_front());
    end
    prev_done = done;
  end

  task automatic run_one(input logic [CW-1:0] cin, input int expv, input string tag);
    int cyc;
    int busy_cycles;
    bit seen;
    @(negedge clk);
    countin = cin;
    start = 1'b1;
    sb.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
    countin = CW'({$urandom, $urandom});
    busy_cycles = busy ? 1 : 0;
    seen = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cycles++;
      if (done) begin
        cyc = k;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
    else begin
      chk({tag, "_latency"}, cyc, SI - 1);
      chk({tag, "_busy_cycles"}, busy_cycles, SI);
    end
    @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int base;
    vecs[0] = '{40'h00_0000_0000, 0};
    vecs[1] = '{40'h00_0000_001F, 31};
    vecs[2] = '{40'hF8_4000_0000, -64};
    vecs[3] = '{40'h80_0000_0000, -2048};
    vecs[4] = '{40'h7F_FFFF_FFFF, 5857};
    vecs[5] = '{40'h00_0000_0060, 6};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'($signed(result)), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_one(vecs[i].cin, relu(vecs[i].expv), $sformatf("vec%0d", i));

    // Reset three cycles into RUN: outputs clear at once and no done ever appears.
    @(negedge clk);
    countin = 40'h7F_FFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_result", int'($signed(result)), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, base);
    run_one(40'h00_0000_0060, 6, "after_rst");

    // start held high with countin changing every cycle: one acceptance per SI+1 cycles.
    base = done_cnt;
    for (int c = 0; c < 4 * (SI + 1); c++) begin
      @(negedge clk);
      countin = CW'({$urandom, $urandom});
      start = 1'b1;
      if (c % (SI + 1) == 0) sb.push_back(model(countin));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (SI + 4) @(posedge clk);
    #1;
    chk("held_done_count", done_cnt - base, 4);
    chk("held_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
